// File: rtl/md6button_reader.sv
// Scans a Mega Drive 6-button pad through its TH/select line and presents active-low button states.
// Shadow registers collect one full scan; the outputs update together with a one-cycle scan_done pulse.
module md6button_reader #(
  parameter int PHASE_CYCLES = 200,
  parameter int IDLE_CYCLES  = 40000
) (
  input  logic       system_clock,
  input  logic       reset,
  input  logic [5:0] md_d,
  output logic       md_sel,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       i,
  output logic       ii,
  output logic       iii,
  output logic       iv,
  output logic       v,
  output logic       vi,
  output logic       select,
  output logic       start,
  output logic       six_button,
  output logic       scan_done
);

  localparam int MAXC = (IDLE_CYCLES > PHASE_CYCLES) ? IDLE_CYCLES : PHASE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  // Encoding chosen so that bit 0 set means an even phase (select low).
  typedef enum logic [3:0] {
    IDLE = 4'd0, PH0 = 4'd1, PH1 = 4'd2, PH2 = 4'd3, PH3 = 4'd4,
    PH4  = 4'd5, PH5 = 4'd6, PH6 = 4'd7, PH7 = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          md_sel_q, md_sel_d;
  logic          last;

  logic [5:0] sync1_q, sync2_q;
  logic sh_up_q, sh_down_q, sh_left_q, sh_right_q, sh_a_q, sh_b_q, sh_c_q, sh_start_q;
  logic sh_x_q, sh_y_q, sh_z_q, sh_mode_q, sh_six_q;
  logic up_q, down_q, left_q, right_q, i_q, ii_q, iii_q, iv_q, v_q, vi_q;
  logic select_q, start_q, six_q, done_q;

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      md_sel_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      md_sel_q <= md_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    last    = (state_q == IDLE) ? (cnt_q == CW'(IDLE_CYCLES - 1))
                                : (cnt_q == CW'(PHASE_CYCLES - 1));
    if (last) begin
      cnt_d = '0;
      case (state_q)
        IDLE:    state_d = PH0;
        PH7:     state_d = IDLE;
        default: state_d = state_t'(state_q + 4'd1);
      endcase
    end
    md_sel_d = ~state_d[0];
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      sh_up_q    <= 1'b1;
      sh_down_q  <= 1'b1;
      sh_left_q  <= 1'b1;
      sh_right_q <= 1'b1;
      sh_a_q     <= 1'b1;
      sh_b_q     <= 1'b1;
      sh_c_q     <= 1'b1;
      sh_start_q <= 1'b1;
      sh_x_q     <= 1'b1;
      sh_y_q     <= 1'b1;
      sh_z_q     <= 1'b1;
      sh_mode_q  <= 1'b1;
      sh_six_q   <= 1'b0;
    end else begin
      sync1_q <= md_d;
      sync2_q <= sync1_q;
      if (last) begin
        case (state_q)
          PH0: begin
            sh_a_q     <= sync2_q[4];
            sh_start_q <= sync2_q[5];
          end
          PH1: begin
            sh_up_q    <= sync2_q[0];
            sh_down_q  <= sync2_q[1];
            sh_left_q  <= sync2_q[2];
            sh_right_q <= sync2_q[3];
            sh_b_q     <= sync2_q[4];
            sh_c_q     <= sync2_q[5];
          end
          PH4: sh_six_q <= (sync2_q[3:0] == 4'b0000);
          PH5: begin
            sh_z_q    <= sync2_q[0];
            sh_y_q    <= sync2_q[1];
            sh_x_q    <= sync2_q[2];
            sh_mode_q <= sync2_q[3];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      {up_q, down_q, left_q, right_q} <= 4'hF;
      {i_q, ii_q, iii_q, iv_q, v_q, vi_q} <= 6'h3F;
      select_q <= 1'b1;
      start_q  <= 1'b1;
      six_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == PH7) && last;
      if ((state_q == PH7) && last) begin
        up_q     <= sh_up_q;
        down_q   <= sh_down_q;
        left_q   <= sh_left_q;
        right_q  <= sh_right_q;
        i_q      <= sh_c_q;
        ii_q     <= sh_b_q;
        iii_q    <= sh_a_q;
        start_q  <= sh_start_q;
        // A 3-button pad has no X/Y/Z/Mode, so those read as released.
        iv_q     <= sh_six_q ? sh_x_q    : 1'b1;
        v_q      <= sh_six_q ? sh_y_q    : 1'b1;
        vi_q     <= sh_six_q ? sh_z_q    : 1'b1;
        select_q <= sh_six_q ? sh_mode_q : 1'b1;
        six_q    <= sh_six_q;
      end
    end
  end

  assign md_sel     = md_sel_q;
  assign up         = up_q;
  assign down       = down_q;
  assign left       = left_q;
  assign right      = right_q;
  assign i          = i_q;
  assign ii         = ii_q;
  assign iii        = iii_q;
  assign iv         = iv_q;
  assign v          = v_q;
  assign vi         = vi_q;
  assign select     = select_q;
  assign start      = start_q;
  assign six_button = six_q;
  assign scan_done  = done_q;

endmodule

// File: tb/tb_md6button_reader.sv
// Bench for md6button_reader: a TH-edge-counting pad model feeds md_d, expected button words
// are queued when a scan's stimulus is set and compared when scan_done pulses.
module tb_md6button_reader;

  localparam int PH = 4;
  localparam int ID = 16;
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_A = 4, B_B = 5;
  localparam int B_C = 6, B_START = 7, B_X = 8, B_Y = 9, B_Z = 10, B_MODE = 11;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] md_d;
  logic md_sel, up, down, left, right, i, ii, iii, iv, v, vi, select, start, six_button, scan_done;

  logic [11:0] pr = '0;
  bit six_pad = 1'b0;
  bit no_pad = 1'b1;
  int fe = 0;
  int hi_cnt = 100;

  logic [12:0] sb[$];
  logic [12:0] exp_w;
  int n_pass = 0;
  int n_total = 0;

  md6button_reader #(.PHASE_CYCLES(PH), .IDLE_CYCLES(ID)) dut (
    .system_clock(clk), .reset(reset), .md_d(md_d), .md_sel(md_sel),
    .up(up), .down(down), .left(left), .right(right),
    .i(i), .ii(ii), .iii(iii), .iv(iv), .v(v), .vi(vi),
    .select(select), .start(start), .six_button(six_button), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Pad: counts select falling edges, restarting after a long high period.
  always @(posedge clk) begin
    if (md_sel === 1'b1) begin
      if (hi_cnt < 1000) hi_cnt <= hi_cnt + 1;
    end else begin
      hi_cnt <= 0;
    end
  end

  always @(negedge md_sel) fe <= (hi_cnt >= 10) ? 1 : fe + 1;

  always_comb begin
    md_d = 6'h3F;
    if (!no_pad) begin
      if (md_sel === 1'b0) begin
        md_d = {~pr[B_START], ~pr[B_A], 2'b00, ~pr[B_DOWN], ~pr[B_UP]};
        if (fe == 3) md_d[3:0] = six_pad ? 4'b0000 : 4'b1111;
        else if (fe == 4 && six_pad) md_d[3:0] = 4'b1111;
      end else begin
        md_d = {~pr[B_C], ~pr[B_B], ~pr[B_RIGHT], ~pr[B_LEFT], ~pr[B_DOWN], ~pr[B_UP]};
        if (fe == 3 && six_pad) md_d[3:0] = {~pr[B_MODE], ~pr[B_X], ~pr[B_Y], ~pr[B_Z]};
      end
    end
  end

  function automatic logic [12:0] expect_of(input logic [11:0] p, input bit six, input bit none);
    if (none) return {1'b0, 12'hFFF};
    return {six, ~p[B_UP], ~p[B_DOWN], ~p[B_LEFT], ~p[B_RIGHT], ~p[B_C], ~p[B_B], ~p[B_A],
            six ? ~p[B_X] : 1'b1, six ? ~p[B_Y] : 1'b1, six ? ~p[B_Z] : 1'b1,
            six ? ~p[B_MODE] : 1'b1, ~p[B_START]};
  endfunction

  function automatic logic [12:0] obs_word();
    return {six_button, up, down, left, right, i, ii, iii, iv, v, vi, select, start};
  endfunction

  task automatic wait_scan_done(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      n++;
      if (scan_done === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    no_pad = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (md_sel === 1'b1) n_pass++;
    else $display("FAIL reset_md_sel got %b want 1", md_sel);
    n_total++;
    if (obs_word() === {1'b0, 12'hFFF}) n_pass++;
    else $display("FAIL reset_outputs got %h want %h", obs_word(), {1'b0, 12'hFFF});
    n_total++;
    if (scan_done === 1'b0) n_pass++;
    else $display("FAIL reset_scan_done got %b want 0", scan_done);
    @(posedge clk);
    #1 reset = 1'b0;
    sb.push_back(expect_of(pr, six_pad, no_pad));
    wait_scan_done(n);
    n_total++;
    if (n == ID + 8 * PH + 1) n_pass++;
    else $display("FAIL first_latency got %0d want %0d", n, ID + 8 * PH + 1);
    exp_w = sb.pop_front();
    n_total++;
    if (obs_word() === exp_w) n_pass++;
    else $display("FAIL first_scan got %h want %h", obs_word(), exp_w);
  endtask

  task automatic test_no_pad;
    int n;
    no_pad = 1'b1;
    pr = 12'hFFF;
    repeat (2) begin
      sb.push_back(expect_of(pr, six_pad, no_pad));
      wait_scan_done(n);
      n_total++;
      if (n == ID + 8 * PH) n_pass++;
      else $display("FAIL no_pad_period got %0d want %0d", n, ID + 8 * PH);
      exp_w = sb.pop_front();
      n_total++;
      if (obs_word() === exp_w) n_pass++;
      else $display("FAIL no_pad_outputs got %h want %h", obs_word(), exp_w);
    end
  endtask

  task automatic run_scan(input string name, input logic [11:0] p, input bit six);
    int n;
    no_pad = 1'b0;
    six_pad = six;
    pr = p;
    sb.push_back(expect_of(pr, six_pad, no_pad));
    wait_scan_done(n);
    exp_w = sb.pop_front();
    n_total++;
    if (n == ID + 8 * PH && obs_word() === exp_w) n_pass++;
    else $display("FAIL %s got %h after %0d want %h after %0d", name, obs_word(), n, exp_w, ID + 8 * PH);
  endtask

  task automatic test_six_button;
    run_scan("six_c_start_z", (12'd1 << B_C) | (12'd1 << B_START) | (12'd1 << B_Z), 1'b1);
    n_total++;
    if (six_button === 1'b1 && i === 1'b0 && start === 1'b0 && vi === 1'b0) n_pass++;
    else $display("FAIL six_named got six=%b i=%b start=%b vi=%b want 1000", six_button, i, start, vi);
    run_scan("six_mapping", (12'd1 << B_UP) | (12'd1 << B_RIGHT) | (12'd1 << B_B) |
             (12'd1 << B_X) | (12'd1 << B_Y) | (12'd1 << B_MODE), 1'b1);
  endtask

  task automatic test_three_button;
    run_scan("three_a_left", (12'd1 << B_A) | (12'd1 << B_LEFT), 1'b0);
    n_total++;
    if (six_button === 1'b0 && iii === 1'b0 && left === 1'b0 && {iv, v, vi, select} === 4'hF) n_pass++;
    else $display("FAIL three_named got six=%b iii=%b left=%b xyzm=%b want 0 0 0 1111",
                  six_button, iii, left, {iv, v, vi, select});
    run_scan("three_masks_xyz", (12'd1 << B_X) | (12'd1 << B_Z) | (12'd1 << B_MODE) |
             (12'd1 << B_DOWN) | (12'd1 << B_START), 1'b0);
  endtask

  task automatic test_mid_scan_change;
    int n;
    no_pad = 1'b0;
    six_pad = 1'b1;
    pr = '0;
    sb.push_back(expect_of(pr, six_pad, no_pad));
    repeat (ID + 2 * PH + 1) @(negedge clk);
    pr[B_UP] = 1'b1;
    sb.push_back(expect_of(pr, six_pad, no_pad));
    wait_scan_done(n);
    n_total++;
    if (n == 8 * PH - 2 * PH - 1) n_pass++;
    else $display("FAIL mid_change_latency got %0d want %0d", n, 8 * PH - 2 * PH - 1);
    exp_w = sb.pop_front();
    n_total++;
    if (obs_word() === exp_w) n_pass++;
    else $display("FAIL mid_change_same_scan got %h want %h", obs_word(), exp_w);
    wait_scan_done(n);
    exp_w = sb.pop_front();
    n_total++;
    if (obs_word() === exp_w && up === 1'b0) n_pass++;
    else $display("FAIL mid_change_next_scan got %h want %h", obs_word(), exp_w);
  endtask

  task automatic test_md_sel_wave;
    int n;
    logic [47:0] wave;
    sb.push_back(expect_of(pr, six_pad, no_pad));
    wave[47] = md_sel;
    for (int k = 1; k < 48; k++) begin
      @(negedge clk);
      wave[47 - k] = md_sel;
    end
    n_total++;
    if (wave === {16'hFFFF, 32'h0F0F0F0F}) n_pass++;
    else $display("FAIL md_sel_wave got %h want %h", wave, {16'hFFFF, 32'h0F0F0F0F});
    wait_scan_done(n);
    exp_w = sb.pop_front();
    n_total++;
    if (n == 1 && obs_word() === exp_w) n_pass++;
    else $display("FAIL wave_scan got %h after %0d want %h after 1", obs_word(), n, exp_w);
  endtask

  task automatic test_reset_mid_scan;
    int n;
    run_scan("pre_abort", (12'd1 << B_C) | (12'd1 << B_START) | (12'd1 << B_Z), 1'b1);
    repeat (ID + 3 * PH + 1) @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++;
    if (md_sel === 1'b1 && obs_word() === {1'b0, 12'hFFF} && scan_done === 1'b0) n_pass++;
    else $display("FAIL abort_reset_state got sel=%b out=%h done=%b want 1 %h 0",
                  md_sel, obs_word(), scan_done, {1'b0, 12'hFFF});
    @(posedge clk);
    #1 reset = 1'b0;
    sb.push_back(expect_of(pr, six_pad, no_pad));
    wait_scan_done(n);
    n_total++;
    if (n == ID + 8 * PH + 1) n_pass++;
    else $display("FAIL abort_latency got %0d want %0d", n, ID + 8 * PH + 1);
    exp_w = sb.pop_front();
    n_total++;
    if (obs_word() === exp_w) n_pass++;
    else $display("FAIL abort_rescan got %h want %h", obs_word(), exp_w);
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 6; k++)
      run_scan("back_to_back", 12'($urandom), bit'($urandom_range(0, 1)));
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_no_pad();
    test_six_button();
    test_three_button();
    test_mid_scan_change();
    test_md_sel_wave();
    test_reset_mid_scan();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/md6button_reader.md
MD6BUTTON_READER -- requirements
Module: md6button_reader

Interface
REQ-001 Parameter PHASE_CYCLES, default 200: system_clock cycles per select phase (10 us at 20 MHz).
REQ-002 Parameter IDLE_CYCLES, default 40000: cycles with md_sel high between scans (2 ms at 20 MHz, above the pad's 1.5 ms counter timeout).
REQ-003 system_clock  in  1  single clock, 20 MHz nominal; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 md_d  in  6  MD pad pins D0..D5, asynchronous, active-low, pulled up.
REQ-006 md_sel  out  1  MD pad TH/select line, registered.
REQ-007 up, down, left, right, i, ii, iii, iv, v, vi, select, start  out  1 each  active-low button states feeding pcesixbutton (0 = pressed).
REQ-008 six_button  out  1  high when the last scan detected a 6-button pad.
REQ-009 scan_done  out  1  one-cycle pulse when outputs are updated.

Function
REQ-010 md_d SHALL pass through a 2-flop synchronizer; all sampling uses synchronized data.
REQ-011 FSM states SHALL be IDLE and PH0..PH7; a cycle counter SHALL measure each state's length.
REQ-012 IDLE SHALL drive md_sel=1 for IDLE_CYCLES, then enter PH0.
REQ-013 PHk SHALL last exactly PHASE_CYCLES; md_sel=0 in even phases and 1 in odd phases; PH7 SHALL return to IDLE.
REQ-014 Sampling SHALL occur on the last cycle of each phase only.
REQ-015 PH0 sample: A=D4, Start=D5.
REQ-016 PH1 sample: Up=D0, Down=D1, Left=D2, Right=D3, B=D4, C=D5.
REQ-017 PH4 sample: 6-button detected iff D0..D3 all 0.
REQ-018 PH5 sample: Z=D0, Y=D1, X=D2, Mode=D3.
REQ-019 Samples SHALL go to shadow registers; outputs SHALL update together on the PH7->IDLE transition, with scan_done=1 that cycle.
REQ-020 Mapping: i=C, ii=B, iii=A, iv=X, v=Y, vi=Z, select=Mode, start=Start, directions direct.
REQ-021 If 6-button not detected: six_button=0; iv, v, vi and select SHALL be 1; i, ii, iii, start and directions SHALL come from the scan.
REQ-022 No pad (all pins pulled high): all button outputs SHALL be 1 and six_button=0.
REQ-023 Scan latency SHALL be 8*PHASE_CYCLES from IDLE exit to scan_done; the scan period SHALL be IDLE_CYCLES+8*PHASE_CYCLES.
REQ-024 Input changes during a scan SHALL affect only the phases sampled after the change; outputs SHALL never show a mix of two scans' shadow data.

Reset
REQ-025 While reset=1: md_sel=1, all button outputs=1, six_button=0, scan_done=0, FSM=IDLE, counter=0, shadow registers=1.
REQ-026 Reset during a scan SHALL abort it with no output update; the first scan_done after release SHALL come IDLE_CYCLES+8*PHASE_CYCLES+1 cycles later.

Verification (PHASE_CYCLES=4, IDLE_CYCLES=16; pad model with TH-edge counter)
REQ-027 6-button pad, C, Start and Z pressed -> at scan_done: i=0, start=0, vi=0, all other buttons=1, six_button=1.
REQ-028 3-button pad (PH4 returns D0..D3 = 1111), A and Left pressed -> iii=0, left=0, iv/v/vi/select=1, six_button=0.
REQ-029 md_d held at 6'b111111 -> all outputs 1, six_button=0; scan_done pulses every 48 cycles.
REQ-030 Reset asserted mid-PH3 -> md_sel=1 and outputs=1 immediately; no scan_done until 49 cycles after release.
REQ-031 Up released to pressed mid-PH2 -> up unchanged at that scan_done and 0 at the next.
REQ-032 md_sel waveform checked: 16 cycles high, then alternating 4-cycle low/high phases starting low, eight phases in total.
